// File: rtl/test_sequencer_pkg.sv
// Shared encodings for the bus test sequencer: FSM states, run modes and
// the saturation limit of the result counters.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone,
        StCheck,
        StNext
    } state_e;

    typedef enum logic [1:0] {
        ModeWriteOnly     = 2'd0,
        ModeReadOnly      = 2'd1,
        ModeWriteReadback = 2'd2
    } mode_e;

    localparam logic [7:0] CntSat = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CntSat) ? v : v + 8'd1;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            ModeWriteOnly: return ModeReadOnly;
            ModeReadOnly:  return ModeWriteReadback;
            default:       return ModeWriteOnly;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    // The counter only runs while the synchronised level differs from the
    // accepted level; any return to the accepted level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse    <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            pulse   <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
                pulse    <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Button-driven bus exerciser: issues NUM_TXN write / read / write-readback
// transactions to a bus master and tallies pass/fail results.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDRS_WIDTH = 15,
    parameter int unsigned NUM_TXN     = 4,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned TIMEOUT_LEN = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_start,
    input  logic                   btn_mode,
    input  logic                   btn_clear,
    input  logic [ADDRS_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0]  seed,
    output logic                   m_hold,
    output logic                   m_execute,
    output logic                   m_RW,
    output logic [ADDRS_WIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0]  m_din,
    input  logic [DATA_WIDTH-1:0]  m_dout,
    input  logic                   m_dvalid,
    input  logic                   m_master_bsy,
    output logic                   seq_busy,
    output logic [1:0]             mode,
    output logic [7:0]             pass_cnt,
    output logic [7:0]             fail_cnt,
    output logic                   timeout_err,
    output logic [DATA_WIDTH-1:0]  disp_val
);

    localparam int unsigned IW = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;

    logic start_p;
    logic mode_p;
    logic clear_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .pulse (start_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .pulse (mode_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    state_e                 state_q;
    mode_e                  mode_q;
    logic [IW-1:0]          idx_q;
    logic                   rd_phase_q;
    logic                   got_dv_q;
    logic [TIMEOUT_LEN-1:0] tmo_q;

    logic [ADDRS_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]  cur_pat;
    logic                   cur_write;

    assign cur_addr  = base_addr + ADDRS_WIDTH'(idx_q);
    assign cur_pat   = seed + DATA_WIDTH'(idx_q);
    // Readback runs use the write phase first, then the read of the same index.
    assign cur_write = (mode_q == ModeWriteOnly) ||
                       ((mode_q == ModeWriteReadback) && !rd_phase_q);
    assign mode      = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= ModeWriteOnly;
            idx_q       <= '0;
            rd_phase_q  <= 1'b0;
            got_dv_q    <= 1'b0;
            tmo_q       <= '0;
            m_hold      <= 1'b0;
            m_execute   <= 1'b0;
            m_RW        <= 1'b0;
            m_address   <= '0;
            m_din       <= '0;
            seq_busy    <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
            disp_val    <= '0;
        end else begin
            m_execute <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_p) begin
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        timeout_err <= 1'b0;
                    end
                    if (mode_p) begin
                        mode_q <= next_mode(mode_q);
                    end
                    if (start_p) begin
                        state_q    <= StIssue;
                        idx_q      <= '0;
                        rd_phase_q <= 1'b0;
                        seq_busy   <= 1'b1;
                    end
                end
                StIssue: begin
                    if (mode_q == ModeWriteReadback && !rd_phase_q) begin
                        m_hold <= 1'b1;
                    end
                    if (!m_master_bsy) begin
                        m_execute <= 1'b1;
                        m_RW      <= cur_write;
                        m_address <= cur_addr;
                        m_din     <= cur_pat;
                        if (cur_write) begin
                            disp_val <= cur_pat;
                        end
                        if (rd_phase_q) begin
                            m_hold <= 1'b0;
                        end
                        got_dv_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= StWaitAck;
                    end
                end
                StWaitAck, StWaitDone: begin
                    if (!m_RW && m_dvalid && !got_dv_q) begin
                        disp_val <= m_dout;
                        got_dv_q <= 1'b1;
                    end
                    if (tmo_q == '1) begin
                        timeout_err <= 1'b1;
                        fail_cnt    <= sat_inc(fail_cnt);
                        m_hold      <= 1'b0;
                        state_q     <= StNext;
                    end else if (state_q == StWaitAck && m_master_bsy) begin
                        tmo_q   <= '0;
                        state_q <= StWaitDone;
                    end else if (state_q == StWaitDone && !m_master_bsy) begin
                        state_q <= StCheck;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StCheck: begin
                    state_q <= StNext;
                    case (mode_q)
                        ModeWriteOnly: pass_cnt <= sat_inc(pass_cnt);
                        ModeReadOnly: begin
                            if (got_dv_q) pass_cnt <= sat_inc(pass_cnt);
                            else          fail_cnt <= sat_inc(fail_cnt);
                        end
                        default: begin
                            if (!rd_phase_q) begin
                                rd_phase_q <= 1'b1;
                                state_q    <= StIssue;
                            end else if (got_dv_q && disp_val == m_din) begin
                                pass_cnt <= sat_inc(pass_cnt);
                            end else begin
                                fail_cnt <= sat_inc(fail_cnt);
                            end
                        end
                    endcase
                end
                StNext: begin
                    rd_phase_q <= 1'b0;
                    if (idx_q == IW'(NUM_TXN - 1)) begin
                        state_q  <= StIdle;
                        seq_busy <= 1'b0;
                        m_hold   <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StIssue;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: bus master / memory model plus an
// execute-pulse scoreboard fed by each scenario task.
`timescale 1ns/1ps
module tb_test_sequencer;

    localparam int DW = 8;
    localparam int AW = 15;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_start, btn_mode, btn_clear;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] seed;
    logic          m_hold, m_execute, m_RW;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_din, m_dout;
    logic          m_dvalid, m_master_bsy;
    logic          seq_busy;
    logic [1:0]    mode;
    logic [7:0]    pass_cnt, fail_cnt;
    logic          timeout_err;
    logic [DW-1:0] disp_val;

    always #5 clk = ~clk;

    test_sequencer #(
        .DATA_WIDTH  (DW),
        .ADDRS_WIDTH (AW),
        .NUM_TXN     (NT),
        .DEB_CYCLES  (16),
        .TIMEOUT_LEN (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_mode     (btn_mode),
        .btn_clear    (btn_clear),
        .base_addr    (base_addr),
        .seed         (seed),
        .m_hold       (m_hold),
        .m_execute    (m_execute),
        .m_RW         (m_RW),
        .m_address    (m_address),
        .m_din        (m_din),
        .m_dout       (m_dout),
        .m_dvalid     (m_dvalid),
        .m_master_bsy (m_master_bsy),
        .seq_busy     (seq_busy),
        .mode         (mode),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .timeout_err  (timeout_err),
        .disp_val     (disp_val)
    );

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          hold;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e, mon_g;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exec_cnt = 0;

    // Master / memory model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            mm_busy_len = 5;
    logic          mm_enable = 1'b1;
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    int            mm_cnt;
    logic          mm_rw;
    logic [AW-1:0] mm_addr;

    always @(posedge clk) begin
        if (rst) begin
            m_master_bsy <= 1'b0;
            m_dvalid     <= 1'b0;
            m_dout       <= '0;
            mm_cnt       <= 0;
        end else begin
            m_dvalid <= 1'b0;
            if (mm_cnt != 0) begin
                mm_cnt <= mm_cnt - 1;
                if (mm_cnt == 1) m_master_bsy <= 1'b0;
                if (mm_cnt == 2 && !mm_rw) begin
                    m_dvalid <= 1'b1;
                    m_dout   <= mem[mm_addr] ^ ((corrupt_en && mm_addr == corrupt_addr) ? 8'hFF : 8'h00);
                end
            end else if (m_execute && mm_enable) begin
                m_master_bsy <= 1'b1;
                mm_cnt       <= mm_busy_len;
                mm_rw        <= m_RW;
                mm_addr      <= m_address;
                if (m_RW) mem[m_address] <= m_din;
            end
        end
    end

    // Scoreboard consumer and hold-gap monitor
    logic check_hold = 1'b0;
    logic in_pair = 1'b0;
    logic hold_dropped = 1'b0;

    always @(posedge clk) begin
        if (m_execute) begin
            exec_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_exec: got rw=%0b addr=%h data=%h, required no execute",
                         m_RW, m_address, m_din);
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = '{rw: m_RW, addr: m_address, data: m_din, hold: m_hold};
                if (mon_g !== mon_e) begin
                    n_err++;
                    $display("FAIL exec_txn: got rw=%0b addr=%h data=%h hold=%0b, required rw=%0b addr=%h data=%h hold=%0b",
                             mon_g.rw, mon_g.addr, mon_g.data, mon_g.hold,
                             mon_e.rw, mon_e.addr, mon_e.data, mon_e.hold);
                end
            end
            if (check_hold) begin
                if (m_RW) begin
                    in_pair      = 1'b1;
                    hold_dropped = 1'b0;
                end else begin
                    n_cmp++;
                    if (!in_pair || hold_dropped) begin
                        n_err++;
                        $display("FAIL hold_gap: got hold dropped=%0b paired=%0b, required held for whole pair",
                                 hold_dropped, in_pair);
                    end
                    in_pair = 1'b0;
                end
            end
        end else if (check_hold && in_pair && !m_hold) begin
            hold_dropped = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press(input int which, input int hold_cyc, input int settle_cyc);
        @(negedge clk);
        case (which)
            0: btn_start = 1'b1;
            1: btn_mode  = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        repeat (hold_cyc) @(negedge clk);
        btn_start = 1'b0;
        btn_mode  = 1'b0;
        btn_clear = 1'b0;
        repeat (settle_cyc) @(negedge clk);
    endtask

    task automatic push_run(input logic [AW-1:0] b, input logic [DW-1:0] s, input logic rb);
        for (int i = 0; i < NT; i++) begin
            exp_q.push_back('{rw: 1'b1, addr: AW'(b + AW'(i)), data: DW'(s + DW'(i)), hold: rb});
            if (rb) exp_q.push_back('{rw: 1'b0, addr: AW'(b + AW'(i)), data: DW'(s + DW'(i)), hold: 1'b0});
        end
    endtask

    task automatic push_writes(input logic [AW-1:0] b, input logic [DW-1:0] s);
        push_run(b, s, 1'b0);
    endtask

    // Press start, then bound the wait for the run to begin and finish.
    task automatic run(input int budget, input string name);
        int k;
        press(0, 20, 0);
        k = 0;
        while (seq_busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_cmp++;
        if (seq_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: got seq_busy=%0b, required 1", name, seq_busy);
        end
        k = 0;
        while (seq_busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        n_cmp++;
        if (seq_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done: got seq_busy=%0b after %0d cycles, required 0", name, seq_busy, k);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {m_hold, m_execute, m_RW, m_address, m_din, seq_busy, mode,
                pass_cnt, fail_cnt, timeout_err, disp_val};
        n_cmp++;
        if (outs !== 54'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_button_bounce();
        int e0 = exec_cnt;
        press(0, 10, 30);
        n_cmp++;
        if (seq_busy !== 1'b0 || exec_cnt != e0) begin
            n_err++;
            $display("FAIL glitch_start: got busy=%0b execs=%0d, required busy=0 execs=0",
                     seq_busy, exec_cnt - e0);
        end
        press(1, 10, 30);
        n_cmp++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL glitch_mode: got mode=%0d, required 0", mode);
        end
        for (int i = 1; i <= 3; i++) begin
            press(1, 20, 25);
            n_cmp++;
            if (mode !== 2'(i % 3)) begin
                n_err++;
                $display("FAIL mode_step%0d: got mode=%0d, required %0d", i, mode, i % 3);
            end
        end
    endtask

    task automatic test_write_only();
        int e0;
        base_addr = 15'h5555;
        seed = 8'd203;
        mm_busy_len = 5;
        push_writes(base_addr, seed);
        e0 = exec_cnt;
        run(200, "wr_only");
        n_cmp++;
        if (exec_cnt - e0 != NT || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wr_only_execs: got %0d execs (%0d pending), required 4 (0)",
                     exec_cnt - e0, exp_q.size());
        end
        n_cmp++;
        if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wr_only_counts: got pass=%0d fail=%0d, required pass=4 fail=0",
                     pass_cnt, fail_cnt);
        end
        n_cmp++;
        if (disp_val !== 8'd206) begin
            n_err++;
            $display("FAIL wr_only_disp: got %0d, required 206", disp_val);
        end
    endtask

    task automatic test_busy_ignore();
        int e0;
        mm_busy_len = 50;
        push_writes(base_addr, seed);
        e0 = exec_cnt;
        press(0, 20, 0);
        repeat (3) @(negedge clk);
        press(2, 20, 25);
        press(0, 20, 25);
        press(1, 20, 5);
        n_cmp++;
        if (seq_busy !== 1'b1 || mode !== 2'd0) begin
            n_err++;
            $display("FAIL busy_mode_press: got busy=%0b mode=%0d, required busy=1 mode=0",
                     seq_busy, mode);
        end
        for (int k = 0; k < 400 && seq_busy !== 1'b0; k++) @(negedge clk);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (exec_cnt - e0 != NT || seq_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_ignored: got %0d execs busy=%0b, required 4 execs busy=0",
                     exec_cnt - e0, seq_busy);
        end
        n_cmp++;
        if (pass_cnt !== 8'd8) begin
            n_err++;
            $display("FAIL busy_clear_ignored: got pass=%0d, required 8", pass_cnt);
        end
        mm_busy_len = 5;
    endtask

    task automatic test_wrap();
        press(2, 20, 25);
        n_cmp++;
        if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL idle_clear: got pass=%0d fail=%0d, required 0 0", pass_cnt, fail_cnt);
        end
        base_addr = 15'h7FFE;
        seed = 8'hFE;
        push_writes(base_addr, seed);
        run(200, "wrap");
        n_cmp++;
        if (pass_cnt !== 8'd4 || exp_q.size() != 0 || disp_val !== 8'h01) begin
            n_err++;
            $display("FAIL wrap_result: got pass=%0d pending=%0d disp=%h, required 4 0 01",
                     pass_cnt, exp_q.size(), disp_val);
        end
    endtask

    task automatic test_readback();
        press(1, 20, 25);
        press(1, 20, 25);
        n_cmp++;
        if (mode !== 2'd2) begin
            n_err++;
            $display("FAIL rb_mode: got %0d, required 2", mode);
        end
        press(2, 20, 25);
        base_addr = 15'h0100;
        seed = 8'h30;
        check_hold = 1'b1;
        in_pair = 1'b0;
        push_run(base_addr, seed, 1'b1);
        run(400, "rb");
        n_cmp++;
        if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rb_counts: got pass=%0d fail=%0d pending=%0d, required 4 0 0",
                     pass_cnt, fail_cnt, exp_q.size());
        end
        n_cmp++;
        if (disp_val !== 8'h33) begin
            n_err++;
            $display("FAIL rb_disp: got %h, required 33", disp_val);
        end
        press(2, 20, 25);
        corrupt_en = 1'b1;
        corrupt_addr = base_addr + 15'd2;
        push_run(base_addr, seed, 1'b1);
        run(400, "rb_bad");
        n_cmp++;
        if (pass_cnt !== 8'd3 || fail_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rb_corrupt_counts: got pass=%0d fail=%0d, required 3 1",
                     pass_cnt, fail_cnt);
        end
        corrupt_en = 1'b0;
        check_hold = 1'b0;
    endtask

    task automatic test_timeout();
        int t0;
        press(1, 20, 25);
        press(2, 20, 25);
        n_cmp++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL to_mode: got %0d, required 0", mode);
        end
        mm_enable = 1'b0;
        base_addr = 15'h0040;
        seed = 8'h11;
        push_writes(base_addr, seed);
        t0 = exec_cnt;
        run(600, "timeout");
        n_cmp++;
        if (fail_cnt !== 8'd4 || pass_cnt !== 8'd0 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_result: got fail=%0d pass=%0d terr=%0b, required 4 0 1",
                     fail_cnt, pass_cnt, timeout_err);
        end
        n_cmp++;
        if (exec_cnt - t0 != NT) begin
            n_err++;
            $display("FAIL timeout_execs: got %0d, required 4", exec_cnt - t0);
        end
        mm_enable = 1'b1;
        press(2, 20, 25);
        n_cmp++;
        if (timeout_err !== 1'b0 || fail_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL timeout_clear: got terr=%0b fail=%0d, required 0 0", timeout_err, fail_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int e0;
        int k;
        logic [53:0] outs;
        mm_busy_len = 50;
        push_writes(base_addr, seed);
        press(0, 20, 0);
        k = 0;
        while (m_master_bsy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (m_master_bsy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_busy: got m_master_bsy=%0b, required 1", m_master_bsy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        outs = {m_hold, m_execute, m_RW, m_address, m_din, seq_busy, mode,
                pass_cnt, fail_cnt, timeout_err, disp_val};
        n_cmp++;
        if (outs !== 54'd0) begin
            n_err++;
            $display("FAIL midrun_reset_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        e0 = exec_cnt;
        repeat (150) @(negedge clk);
        n_cmp++;
        if (exec_cnt != e0 || seq_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_no_exec: got %0d execs busy=%0b, required 0 execs busy=0",
                     exec_cnt - e0, seq_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0;
        btn_mode = 1'b0;
        btn_clear = 1'b0;
        base_addr = '0;
        seed = '0;
        test_reset();
        test_button_bounce();
        test_write_only();
        test_busy_ignore();
        test_wrap();
        test_readback();
        test_timeout();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
